seg_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment driver for the board's common-anode display bank. Replaces the single-digit static driver with a scanner that:
- drives NUM_DIGITS digits from one packed hex bus, with full 0-F decode;
- supports per-digit decimal point and per-digit blanking;
- offers optional leading-zero suppression;
- inserts anti-ghosting guard cycles between digits;
- latches inputs once per frame so a frame never shows torn values.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg_scan_mux.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the blank pattern, the 0-F glyphs and the
// nibble-to-glyph function. Patterns are active-low with bit 0 = segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = GLYPH_0;
            4'h1:    pattern = GLYPH_1;
            4'h2:    pattern = GLYPH_2;
            4'h3:    pattern = GLYPH_3;
            4'h4:    pattern = GLYPH_4;
            4'h5:    pattern = GLYPH_5;
            4'h6:    pattern = GLYPH_6;
            4'h7:    pattern = GLYPH_7;
            4'h8:    pattern = GLYPH_8;
            4'h9:    pattern = GLYPH_9;
            4'hA:    pattern = GLYPH_A;
            4'hB:    pattern = GLYPH_B;
            4'hC:    pattern = GLYPH_C;
            4'hD:    pattern = GLYPH_D;
            4'hE:    pattern = GLYPH_E;
            4'hF:    pattern = GLYPH_F;
            default: pattern = SEG_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder; the blank pattern covers any
// unknown nibble so the segment bus never carries X.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input
// snapshot, guard blanking between digits, blanking, dp and zero suppression.
module seg_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter int GUARD_CYC  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      lz_en,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic                      frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [GW-1:0]         GUARD_LOAD = GW'(GUARD_CYC);
    localparam logic [GW-1:0]         GUARD_ONE  = GW'(1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{1'b1}};
    localparam bit                    NO_GUARD   = (GUARD_CYC == 0);

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [GW-1:0]           guard_r;
    logic                    en_q_r;
    logic [4*NUM_DIGITS-1:0] snap_digits_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic [NUM_DIGITS-1:0]   snap_blank_r;
    logic                    snap_lz_r;
    logic [NUM_DIGITS-1:0]   sel_r;
    logic [6:0]              seg_r;
    logic                    dp_n_r;
    logic                    frame_start_r;

    logic                    tick_s;
    logic                    wrap_s;
    logic [IW-1:0]           idx_next_s;
    logic [IW-1:0]           disp_idx_s;
    logic [4*NUM_DIGITS-1:0] src_digits_s;
    logic [NUM_DIGITS-1:0]   src_dp_s;
    logic [NUM_DIGITS-1:0]   src_blank_s;
    logic                    src_lz_s;
    logic [3:0]              nibble_s;
    logic [6:0]              glyph_s;
    logic                    upper_nonzero_s;
    logic                    suppress_s;
    logic [NUM_DIGITS-1:0]   sel_digit_s;
    logic [6:0]              seg_digit_s;
    logic                    dp_n_digit_s;
    logic                    dark_s;
    logic                    load_s;

    // Slot tick, frame wrap and next digit index
    always_comb begin
        tick_s = en && (presc_r == PRESC_LAST);
        wrap_s = tick_s && (idx_r == IDX_LAST);
        if (idx_r == IDX_LAST) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + IW'(1);
        end
    end

    // On the wrap tick the incoming inputs feed digit 0 directly, so a
    // guard-less slot 0 already shows the fresh snapshot.
    always_comb begin
        if (tick_s) begin
            disp_idx_s = idx_next_s;
        end else begin
            disp_idx_s = idx_r;
        end
        if (wrap_s) begin
            src_digits_s = digits;
            src_dp_s     = dp;
            src_blank_s  = blank;
            src_lz_s     = lz_en;
        end else begin
            src_digits_s = snap_digits_r;
            src_dp_s     = snap_dp_r;
            src_blank_s  = snap_blank_r;
            src_lz_s     = snap_lz_r;
        end
        nibble_s = src_digits_s[4*disp_idx_s +: 4];
    end

    seg7_hex_decode u_decode (
        .nibble (nibble_s),
        .seg    (glyph_s)
    );

    // Leading-zero test: the shown digit and everything above it are zero
    always_comb begin
        upper_nonzero_s = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IW'(j) >= disp_idx_s) && (src_digits_s[4*j +: 4] != 4'h0)) begin
                upper_nonzero_s = 1'b1;
            end else begin
                upper_nonzero_s = upper_nonzero_s;
            end
        end
        suppress_s = src_lz_s && (disp_idx_s != '0) && !upper_nonzero_s;
    end

    // Lit pattern for the displayed digit
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_digit_s[i] = (IW'(i) != disp_idx_s);
        end
        if (src_blank_s[disp_idx_s]) begin
            seg_digit_s  = SEG_OFF;
            dp_n_digit_s = 1'b1;
        end else if (suppress_s) begin
            seg_digit_s  = SEG_OFF;
            dp_n_digit_s = ~src_dp_s[disp_idx_s];
        end else begin
            seg_digit_s  = glyph_s;
            dp_n_digit_s = ~src_dp_s[disp_idx_s];
        end
    end

    // Dark on disable or at a guarded slot start; otherwise drive the digit
    // once the guard has run out, or at once when resuming from a disable.
    always_comb begin
        dark_s = !en || (tick_s && !NO_GUARD);
        load_s = (tick_s && NO_GUARD) ||
                 (en && !tick_s && ((guard_r <= GUARD_ONE) || !en_q_r));
    end

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= idx_next_s;
        end else if (en) begin
            presc_r <= presc_r + PW'(1);
            idx_r   <= idx_r;
        end else begin
            presc_r <= presc_r;
            idx_r   <= idx_r;
        end
    end

    // Guard countdown and enable history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_r <= '0;
            en_q_r  <= 1'b0;
        end else begin
            en_q_r <= en;
            if (tick_s && !NO_GUARD) begin
                guard_r <= GUARD_LOAD;
            end else if (en && !en_q_r) begin
                guard_r <= '0;
            end else if (en && (guard_r != '0)) begin
                guard_r <= guard_r - GW'(1);
            end else begin
                guard_r <= guard_r;
            end
        end
    end

    // Frame snapshot and frame_start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits_r <= '0;
            snap_dp_r     <= '0;
            snap_blank_r  <= '0;
            snap_lz_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= wrap_s;
            if (wrap_s) begin
                snap_digits_r <= digits;
                snap_dp_r     <= dp;
                snap_blank_r  <= blank;
                snap_lz_r     <= lz_en;
            end else begin
                snap_digits_r <= snap_digits_r;
                snap_dp_r     <= snap_dp_r;
                snap_blank_r  <= snap_blank_r;
                snap_lz_r     <= snap_lz_r;
            end
        end
    end

    // Display output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r  <= SEL_OFF;
            seg_r  <= SEG_OFF;
            dp_n_r <= 1'b1;
        end else if (dark_s) begin
            sel_r  <= SEL_OFF;
            seg_r  <= SEG_OFF;
            dp_n_r <= 1'b1;
        end else if (load_s) begin
            sel_r  <= sel_digit_s;
            seg_r  <= seg_digit_s;
            dp_n_r <= dp_n_digit_s;
        end else begin
            sel_r  <= sel_r;
            seg_r  <= seg_r;
            dp_n_r <= dp_n_r;
        end
    end

    assign sel         = sel_r;
    assign seg         = seg_r;
    assign dp_n        = dp_n_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a guarded 4-digit instance and a
// guard-less 8-digit instance, both compared against an arithmetic model.
module tb_seg_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, lz_en;
    logic [15:0] digits;
    logic [3:0]  dp, blank, sel;
    logic [6:0]  seg;
    logic        dp_n, frame_start;

    logic        rst_n2, en2, lz2;
    logic [31:0] digits2;
    logic [7:0]  dp2, blank2, sel2;
    logic [6:0]  seg2;
    logic        dp_n2, fs2;

    int checks = 0;
    int errors = 0;

    int          k1, k2;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank;
    logic        m_lz, m_en;
    logic [31:0] m2_dig;
    logic [7:0]  m2_dp, m2_blank;
    logic        m2_lz;

    logic [15:0] ev;
    logic        efs;

    seg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .GUARD_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .digits(digits),
        .dp(dp), .blank(blank), .sel(sel), .seg(seg), .dp_n(dp_n),
        .frame_start(frame_start)
    );

    seg_scan_mux #(.NUM_DIGITS(8), .CLK_DIV(2), .GUARD_CYC(0)) dut_fast (
        .clk(clk), .rst_n(rst_n2), .en(en2), .lz_en(lz2), .digits(digits2),
        .dp(dp2), .blank(blank2), .sel(sel2), .seg(seg2), .dp_n(dp_n2),
        .frame_start(fs2)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    // Expected {sel(8), seg, dp_n} after the k-th enabled edge since reset.
    function automatic logic [15:0] exp_view(input int nd, input int cdiv, input int g,
                                             input int k, input logic en_e,
                                             input logic [31:0] sd, input logic [7:0] sdp,
                                             input logic [7:0] sbl, input logic slz);
        int d;
        logic [7:0]  s;
        logic [6:0]  sg;
        logic        dn;
        logic [31:0] upper;
        if (!en_e || (k >= cdiv && (k % cdiv) < g)) return {8'hFF, 7'h7F, 1'b1};
        d     = (k / cdiv) % nd;
        s     = ~(8'd1 << d);
        upper = sd >> (4 * d);
        if (sbl[d]) begin
            sg = 7'h7F;
            dn = 1'b1;
        end else begin
            dn = ~sdp[d];
            if (slz && d > 0 && upper == 32'd0) sg = 7'h7F;
            else sg = glyph(upper[3:0]);
        end
        return {s, sg, dn};
    endfunction

    task automatic step1(output logic [15:0] v, output logic fs);
        @(posedge clk);
        m_en = en;
        fs   = 1'b0;
        if (en) begin
            k1++;
            if (k1 % 16 == 0) begin
                m_dig = digits; m_dp = dp; m_blank = blank; m_lz = lz_en; fs = 1'b1;
            end
        end
        #1;
        v = exp_view(4, 4, 1, k1, m_en, {16'h0, m_dig}, {4'h0, m_dp}, {4'h0, m_blank}, m_lz);
    endtask

    task automatic step2(output logic [15:0] v, output logic fs);
        @(posedge clk);
        fs = 1'b0;
        if (en2) begin
            k2++;
            if (k2 % 16 == 0) begin
                m2_dig = digits2; m2_dp = dp2; m2_blank = blank2; m2_lz = lz2; fs = 1'b1;
            end
        end
        #1;
        v = exp_view(8, 2, 0, k2, en2, m2_dig, m2_dp, m2_blank, m2_lz);
    endtask

    task automatic model1_reset();
        k1 = 0; m_dig = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; lz_en = 1'b0; digits = 16'h1234; dp = 4'h0; blank = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sel, seg, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got sel=%b seg=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
                     sel, seg, dp_n, frame_start);
        end
        model1_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL first_frames k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_lz();
        digits = 16'h00A0; lz_en = 1'b1; dp = 4'b1000;
        for (int c = 0; c < 36; c++) begin
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL lz_suppress k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_snapshot();
        digits = 16'h1111; lz_en = 1'b0; dp = 4'h0;
        for (int c = 0; c < 40; c++) begin
            if (k1 % 16 == 6) digits = 16'h2222;
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL snapshot k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_en_gap();
        for (int c = 0; c < 8 && (k1 % 4) != 2; c++) step1(ev, efs);
        en = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c == 10) en = 1'b1;
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL en_gap k=%0d en=%b: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, m_en, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_blank();
        blank = 4'b0100; dp = 4'b0100; digits = 16'h5678;
        for (int c = 0; c < 34; c++) begin
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL blank k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 240; c++) begin
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL random k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
            if ($urandom_range(0, 3) == 0) digits = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp    = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_en = 1'($urandom);
            en    = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        digits = 16'h9ABC; blank = 4'h0; dp = 4'h0;
        for (int c = 0; c < 6; c++) step1(ev, efs);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, seg, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got sel=%b seg=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
                     sel, seg, dp_n, frame_start);
        end
        @(posedge clk);
        #1;
        model1_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step1(ev, efs);
            checks++;
            if ({4'hF, sel, seg, dp_n, frame_start} !== {ev, efs}) begin
                errors++;
                $display("FAIL post_reset k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k1, sel, seg, dp_n, frame_start, ev[11:8], ev[7:1], ev[0], efs);
            end
        end
    endtask

    task automatic test_fast_no_guard();
        k2 = 0; m2_dig = '0; m2_dp = '0; m2_blank = '0; m2_lz = 1'b0;
        digits2 = 32'($urandom); dp2 = 8'($urandom); blank2 = 8'h00; lz2 = 1'b0;
        rst_n2 = 1'b1;
        for (int c = 0; c < 56; c++) begin
            step2(ev, efs);
            checks++;
            if ({sel2, seg2, dp_n2, fs2} !== {ev, efs}) begin
                errors++;
                $display("FAIL fast_scan k=%0d: got sel=%b seg=%b dp_n=%b fs=%b, want sel=%b seg=%b dp_n=%b fs=%b",
                         k2, sel2, seg2, dp_n2, fs2, ev[15:8], ev[7:1], ev[0], efs);
            end
            if (c == 20) begin
                digits2 = 32'($urandom) >> 12; lz2 = 1'b1; blank2 = 8'($urandom);
            end
        end
        #2;
        rst_n2 = 1'b0;
        #1;
        checks++;
        if ({sel2, seg2, dp_n2, fs2} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fast_async_reset: got sel=%b seg=%b dp_n=%b fs=%b, want 11111111 1111111 1 0",
                     sel2, seg2, dp_n2, fs2);
        end
    endtask

    initial begin
        rst_n2 = 1'b0; en2 = 1'b1; lz2 = 1'b0; digits2 = '0; dp2 = '0; blank2 = '0;
        test_reset();
        test_lz();
        test_snapshot();
        test_en_gap();
        test_blank();
        test_random();
        test_async_reset();
        test_fast_no_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
